// File: rtl/agc_pkg.sv
// Shared types and constants for the AGC control block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package agc_pkg;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_DONE
    } agc_state_t;

    // Unity gain in Q12 on the 17-bit scale path.
    localparam logic [16:0] SCALE_UNITY = 17'd4096;

    // Cycles the DSP needs after an apply before its gt/lt flags are meaningful.
    localparam int SETTLE_DEFAULT = 6;

endpackage

// File: rtl/agc_sat_cnt.sv
// Saturating event counter: counts inc_i cycles, sticks at all-ones, clr_i zeroes.
// Latency: count updates one cycle after inc_i/clr_i.
// Backpressure: none; clr_i has priority over inc_i.
//
// Ports: clk_i/rst_i clock and async active-high reset; clr_i synchronous clear;
//        inc_i count enable; cnt_o current count.
module agc_sat_cnt #(
    parameter int W = 24
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_o <= '0;
        end else if (clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != {W{1'b1}})) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/agc_ctrl.sv
// AGC control: stages scale/offset for a two-stage DSP, sequences applies, measures gt/lt windows.
// Latency: writes visible (ce pulse) next cycle; apply issues one cycle after the last ce-producing write.
// Backpressure: none; apply requests are latched and merged, start_i is ignored while busy.
//
// Ports: clk_i/rst_i clock and async active-high reset.
//        scale_wr_i/scale_dat_i, offset_wr_i/offset_dat_i stage first-stage values (ce_*_o pulses).
//        apply_req_i requests apply_o (second-stage capture); pending_o = staged but not applied.
//        start_i/window_i start a measurement; gt_i/lt_i DSP flags; busy_o, done_o, gt_cnt_o, lt_cnt_o results.
module agc_ctrl #(
    parameter int OFFSET_BITS = 12,
    parameter int CNT_BITS    = 24,
    parameter int SETTLE      = agc_pkg::SETTLE_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   scale_wr_i,
    input  logic [16:0]            scale_dat_i,
    input  logic                   offset_wr_i,
    input  logic [OFFSET_BITS-1:0] offset_dat_i,
    input  logic                   apply_req_i,
    input  logic                   start_i,
    input  logic [CNT_BITS-1:0]    window_i,
    input  logic                   gt_i,
    input  logic                   lt_i,
    output logic [16:0]            scale_o,
    output logic [OFFSET_BITS-1:0] offset_o,
    output logic                   ce_scale_o,
    output logic                   ce_offset_o,
    output logic                   apply_o,
    output logic                   pending_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [CNT_BITS-1:0]    gt_cnt_o,
    output logic [CNT_BITS-1:0]    lt_cnt_o
);
    import agc_pkg::*;

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    // ---------------------------------------------------------------
    // Staging and apply sequencing
    // ---------------------------------------------------------------
    logic wr_any;
    logic apply_lat;
    logic init_apply;
    logic apply_want;
    logic apply_issue;

    assign wr_any      = scale_wr_i | offset_wr_i;
    // init_apply makes the second stage pick up the reset values right after reset.
    assign apply_want  = apply_lat | apply_req_i | init_apply;
    // A write this cycle means a ce pulse next cycle; hold the apply so the
    // second stage never samples in the same cycle the first stage is loading.
    assign apply_issue = apply_want & ~wr_any;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scale_o     <= SCALE_UNITY;
            offset_o    <= '0;
            ce_scale_o  <= 1'b0;
            ce_offset_o <= 1'b0;
            apply_o     <= 1'b0;
            pending_o   <= 1'b0;
            apply_lat   <= 1'b0;
            init_apply  <= 1'b1;
        end else begin
            ce_scale_o  <= scale_wr_i;
            ce_offset_o <= offset_wr_i;
            if (scale_wr_i) begin
                scale_o <= scale_dat_i;
            end
            if (offset_wr_i) begin
                offset_o <= offset_dat_i;
            end
            apply_o    <= apply_issue;
            // Deferred requests (including the post-reset one) merge here.
            apply_lat  <= apply_want & wr_any;
            init_apply <= 1'b0;
            // A fresh write wins over an apply that lands in the same cycle.
            if (wr_any) begin
                pending_o <= 1'b1;
            end else if (apply_o) begin
                pending_o <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------
    // Measurement sequencer
    // ---------------------------------------------------------------
    agc_state_t          state;
    logic [SET_W-1:0]    settle_cnt;
    logic [CNT_BITS-1:0] win_q;
    logic [CNT_BITS-1:0] win_cnt;
    logic [CNT_BITS-1:0] gt_cnt;
    logic [CNT_BITS-1:0] lt_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            settle_cnt <= '0;
            win_q      <= '0;
            win_cnt    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            gt_cnt_o   <= '0;
            lt_cnt_o   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        win_q      <= window_i;
                        busy_o     <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    // Settling is timed from the most recent apply.
                    if (apply_o) begin
                        settle_cnt <= '0;
                    end else if (settle_cnt == SET_W'(SETTLE - 1)) begin
                        win_cnt <= '0;
                        if (win_q == '0) begin
                            state  <= ST_DONE;
                            busy_o <= 1'b0;
                        end else begin
                            state <= ST_COUNT;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                ST_COUNT: begin
                    // A new apply invalidates everything measured so far.
                    if (apply_o) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                    end else if (win_cnt == win_q - CNT_BITS'(1)) begin
                        state  <= ST_DONE;
                        busy_o <= 1'b0;
                    end else begin
                        win_cnt <= win_cnt + CNT_BITS'(1);
                    end
                end
                ST_DONE: begin
                    gt_cnt_o <= gt_cnt;
                    lt_cnt_o <= lt_cnt;
                    done_o   <= 1'b1;
                    state    <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    // Counters are held at zero throughout SETTLE so every COUNT starts clean.
    logic cnt_clr;
    logic in_count;
    assign cnt_clr  = (state == ST_SETTLE);
    assign in_count = (state == ST_COUNT);

    agc_sat_cnt #(.W(CNT_BITS)) u_gt_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .inc_i (in_count & gt_i),
        .cnt_o (gt_cnt)
    );

    agc_sat_cnt #(.W(CNT_BITS)) u_lt_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clr_i (cnt_clr),
        .inc_i (in_count & lt_i),
        .cnt_o (lt_cnt)
    );

endmodule

// File: tb/tb_agc_ctrl.sv
// Bench for agc_ctrl: table of staging/apply vectors plus directed measurement sequences.
module tb_agc_ctrl;

    localparam int OB = 12;
    localparam int CB = 24;
    localparam int ST = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          scale_wr, offset_wr, apply_req, start, gt, lt;
    logic [16:0]   scale_dat;
    logic [OB-1:0] offset_dat;
    logic [CB-1:0] window;
    logic          start4, gt4;
    logic [3:0]    window4;

    logic [16:0]   scale_q, scale4_q;
    logic [OB-1:0] offset_q, offset4_q;
    logic          ce_s, ce_o, apply_q, pend_q, busy_q, done_q;
    logic          ce_s4, ce_o4, apply4_q, pend4_q, busy4_q, done4_q;
    logic [CB-1:0] gtc, ltc;
    logic [3:0]    gtc4, ltc4;

    agc_ctrl #(.OFFSET_BITS(OB), .CNT_BITS(CB), .SETTLE(ST)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .scale_wr_i(scale_wr), .scale_dat_i(scale_dat),
        .offset_wr_i(offset_wr), .offset_dat_i(offset_dat),
        .apply_req_i(apply_req), .start_i(start), .window_i(window),
        .gt_i(gt), .lt_i(lt),
        .scale_o(scale_q), .offset_o(offset_q),
        .ce_scale_o(ce_s), .ce_offset_o(ce_o), .apply_o(apply_q),
        .pending_o(pend_q), .busy_o(busy_q), .done_o(done_q),
        .gt_cnt_o(gtc), .lt_cnt_o(ltc)
    );

    agc_ctrl #(.OFFSET_BITS(OB), .CNT_BITS(4), .SETTLE(ST)) u_dut4 (
        .clk_i(clk), .rst_i(rst),
        .scale_wr_i(scale_wr), .scale_dat_i(scale_dat),
        .offset_wr_i(offset_wr), .offset_dat_i(offset_dat),
        .apply_req_i(apply_req), .start_i(start4), .window_i(window4),
        .gt_i(gt4), .lt_i(lt),
        .scale_o(scale4_q), .offset_o(offset4_q),
        .ce_scale_o(ce_s4), .ce_offset_o(ce_o4), .apply_o(apply4_q),
        .pending_o(pend4_q), .busy_o(busy4_q), .done_o(done4_q),
        .gt_cnt_o(gtc4), .lt_cnt_o(ltc4)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          swr;
        logic [16:0]   sdat;
        logic          owr;
        logic [OB-1:0] odat;
        logic          req;
        logic          e_ces;
        logic          e_ceo;
        logic          e_apply;
        logic          e_pend;
        logic [16:0]   e_scale;
        logic [OB-1:0] e_off;
    } vec_t;

    vec_t vt[16];

    // Drives one measurement on the main DUT: start in cycle 0, then per cycle j
    // gt/lt windows, an optional apply request and an optional second start.
    task automatic run_meas(input int win, input int gt_lo, input int gt_hi,
                            input int lt_lo, input int lt_hi, input int req_at,
                            input int start2_at, input int budget,
                            output int done_at, output int n_done,
                            output logic [511:0] btr);
        done_at = -1;
        n_done  = 0;
        btr     = '0;
        start   = 1'b1;
        window  = CB'(win);
        gt      = 1'b0;
        lt      = 1'b0;
        tick();
        for (int j = 1; j <= budget; j++) begin
            btr[j] = busy_q;
            if (done_q) begin
                n_done++;
                if (done_at < 0) done_at = j;
            end
            start     = (j == start2_at);
            window    = (j == start2_at) ? CB'(3) : CB'(win);
            gt        = (j >= gt_lo) && (j <= gt_hi);
            lt        = (j >= lt_lo) && (j <= lt_hi);
            apply_req = (j == req_at);
            tick();
        end
        start     = 1'b0;
        gt        = 1'b0;
        lt        = 1'b0;
        apply_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_at, nd, n_app;
        logic [511:0] bt;

        //                 swr sdat  owr odat req  ces ceo app pend scale off
        vt[0]  = '{1'b1, 17'd8192, 1'b0, 12'd0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 17'd8192, 12'd0};
        vt[1]  = '{1'b0, 17'd0,    1'b0, 12'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 17'd8192, 12'd0};
        vt[2]  = '{1'b0, 17'd0,    1'b0, 12'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd8192, 12'd0};
        vt[3]  = '{1'b1, 17'd5000, 1'b1, 12'd100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 17'd5000, 12'd100};
        vt[4]  = '{1'b0, 17'd0,    1'b0, 12'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 17'd5000, 12'd100};
        vt[5]  = '{1'b0, 17'd0,    1'b0, 12'd0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 17'd5000, 12'd100};
        vt[6]  = '{1'b0, 17'd0,    1'b0, 12'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd5000, 12'd100};
        vt[7]  = '{1'b0, 17'd0,    1'b0, 12'd0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 17'd5000, 12'd100};
        vt[8]  = '{1'b0, 17'd0,    1'b0, 12'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd5000, 12'd100};
        vt[9]  = '{1'b1, 17'd300,  1'b0, 12'd0,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 17'd300,  12'd100};
        vt[10] = '{1'b0, 17'd0,    1'b1, 12'd7,   1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 17'd300,  12'd7};
        vt[11] = '{1'b0, 17'd0,    1'b0, 12'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 17'd300,  12'd7};
        vt[12] = '{1'b0, 17'd0,    1'b0, 12'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd300,  12'd7};
        vt[13] = '{1'b1, 17'd400,  1'b0, 12'd0,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 17'd400,  12'd7};
        vt[14] = '{1'b0, 17'd0,    1'b0, 12'd0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 17'd400,  12'd7};
        vt[15] = '{1'b0, 17'd0,    1'b0, 12'd0,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 17'd400,  12'd7};

        rst = 1'b1;
        scale_wr = 0; scale_dat = '0; offset_wr = 0; offset_dat = '0;
        apply_req = 0; start = 0; window = '0; gt = 0; lt = 0;
        start4 = 0; window4 = '0; gt4 = 0;
        #1;
        chk("rst_scale", 32'(scale_q), 4096);
        chk("rst_offset", 32'(offset_q), 0);
        chk("rst_apply", 32'(apply_q), 0);
        chk("rst_pending", 32'(pend_q), 0);
        chk("rst_busy", 32'(busy_q), 0);
        repeat (3) tick();
        rst = 1'b0;
        chk("rel_apply_c0", 32'(apply_q), 0);
        tick();
        chk("rel_apply_c1", 32'(apply_q), 1);
        chk("rel_pending_c1", 32'(pend_q), 0);
        chk("rel_scale_c1", 32'(scale_q), 4096);
        tick();
        chk("rel_apply_c2", 32'(apply_q), 0);

        // Staging / apply table
        for (int i = 0; i < 16; i++) begin
            scale_wr   = vt[i].swr;
            scale_dat  = vt[i].sdat;
            offset_wr  = vt[i].owr;
            offset_dat = vt[i].odat;
            apply_req  = vt[i].req;
            tick();
            chk($sformatf("v%0d_ce_scale", i), 32'(ce_s), 32'(vt[i].e_ces));
            chk($sformatf("v%0d_ce_offset", i), 32'(ce_o), 32'(vt[i].e_ceo));
            chk($sformatf("v%0d_apply", i), 32'(apply_q), 32'(vt[i].e_apply));
            chk($sformatf("v%0d_pending", i), 32'(pend_q), 32'(vt[i].e_pend));
            chk($sformatf("v%0d_scale", i), 32'(scale_q), 32'(vt[i].e_scale));
            chk($sformatf("v%0d_offset", i), 32'(offset_q), 32'(vt[i].e_off));
        end
        scale_wr = 0; offset_wr = 0; apply_req = 0;
        repeat (3) tick();

        // Window 100: gt in SETTLE and first 30 COUNT cycles, lt overlapping the
        // last 5 of them, ignored second start at cycle 50.
        run_meas(100, 1, 36, 32, 36, -1, 50, 200, d_at, nd, bt);
        chk("A_done_at", 32'(d_at), 32'(ST + 102));
        chk("A_done_count", 32'(nd), 1);
        chk("A_gt_cnt", 32'(gtc), 30);
        chk("A_lt_cnt", 32'(ltc), 5);
        chk("A_busy_first", 32'(bt[1]), 1);
        chk("A_busy_last_count", 32'(bt[ST + 100]), 1);
        chk("A_busy_in_done", 32'(bt[ST + 101]), 0);
        repeat (3) tick();

        // Window 0: straight to DONE with zero counts.
        run_meas(0, 1, 20, 1, 20, -1, -1, 40, d_at, nd, bt);
        chk("B_done_at", 32'(d_at), 32'(ST + 2));
        chk("B_done_count", 32'(nd), 1);
        chk("B_gt_cnt", 32'(gtc), 0);
        chk("B_lt_cnt", 32'(ltc), 0);
        repeat (3) tick();

        // Apply mid-COUNT restarts SETTLE and clears counters.
        run_meas(100, 1, 400, -1, -2, 56, -1, 250, d_at, nd, bt);
        chk("C_done_at", 32'(d_at), 32'(57 + ST + 102));
        chk("C_done_count", 32'(nd), 1);
        chk("C_gt_cnt", 32'(gtc), 100);
        chk("C_lt_cnt", 32'(ltc), 0);
        chk("C_busy_resettle", 32'(bt[60]), 1);
        repeat (3) tick();

        // Narrow counter instance: full 15-cycle window, gt always high.
        d_at = -1; nd = 0;
        start4 = 1'b1; window4 = 4'd15; gt4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int j = 1; j <= 60; j++) begin
            if (done4_q) begin
                nd++;
                if (d_at < 0) d_at = j;
            end
            tick();
        end
        gt4 = 1'b0;
        chk("D_done_at", 32'(d_at), 32'(ST + 17));
        chk("D_done_count", 32'(nd), 1);
        chk("D_gt_cnt", 32'(gtc4), 15);
        chk("D_lt_cnt", 32'(ltc4), 0);

        // Reset in the middle of COUNT.
        start = 1'b1; window = CB'(100); gt = 1'b1;
        tick();
        start = 1'b0;
        repeat (30) tick();
        chk("E_busy_before", 32'(busy_q), 1);
        rst = 1'b1;
        #1;
        chk("E_busy", 32'(busy_q), 0);
        chk("E_done", 32'(done_q), 0);
        chk("E_scale", 32'(scale_q), 4096);
        chk("E_offset", 32'(offset_q), 0);
        chk("E_pending", 32'(pend_q), 0);
        chk("E_gt_cnt", 32'(gtc), 0);
        chk("E_ce_scale", 32'(ce_s), 0);
        tick();
        tick();
        rst = 1'b0;
        gt  = 1'b0;
        nd = 0; n_app = 0;
        for (int j = 0; j < 150; j++) begin
            tick();
            if (done_q) nd++;
            if (apply_q) n_app++;
        end
        chk("E_no_done", 32'(nd), 0);
        chk("E_post_rst_apply", 32'(n_app), 1);
        chk("E_busy_after", 32'(busy_q), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
